shape_processor_mc: RTL

Multi-channel successor to the single-channel shape control register. Holds `NUM_CHANNELS` independent CTRL registers (shape + operation), each with legality checking and keep-on-all-ones field semantics. Adds per-channel STATUS with a saturating rejected-write counter and sticky error flag, addressed access, and a registered read path. Sits on the processor's register bus; CTRL outputs feed the shape datapath.

---
 rtl/shape_processor_pkg.sv | 46 ++++
 rtl/shape_processor_mc_channel.sv | 69 ++++++
 rtl/shape_processor_mc.sv | 97 +++++++++
 3 files changed

// File: rtl/shape_processor_pkg.sv
// Shared types, register map constants and legality rules for the
// multi-channel shape control block.
//   shape_t      : 2-bit shape code (one-hot when legal)
//   operation_t  : 5-bit operation code, class in [4:3], sub-op in [2:0]
package shape_processor_pkg;

    typedef logic [1:0] shape_t;
    typedef logic [4:0] operation_t;

    // Register select (address bit 0)
    localparam logic REG_CTRL   = 1'b0;
    localparam logic REG_STATUS = 1'b1;

    // Field positions
    localparam int SHAPE_LSB  = 16;
    localparam int OP_LSB     = 0;
    localparam int STICKY_BIT = 16;
    localparam int CLEAR_BIT  = 16;

    // Reset values and keep-current encodings
    localparam shape_t     SHAPE_RST = 2'b01;
    localparam operation_t OP_RST    = 5'b00000;
    localparam shape_t     SHAPE_KEEP = 2'b11;
    localparam operation_t OP_KEEP    = 5'b11111;

    function automatic logic is_legal_shape(input shape_t s);
        return (s == 2'b01) || (s == 2'b10);
    endfunction

    function automatic logic is_legal_operation(input operation_t op);
        logic ok;
        case (op[4:3])
            2'b00:   ok = (op[2:1] == 2'b00);
            2'b01:   ok = (op[2:0] == 3'b000);
            2'b10:   ok = (op[2:1] == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Class 00 works with any shape; other classes must match the shape code.
    function automatic logic is_legal_combination(input shape_t s, input operation_t op);
        return (op[4:3] == 2'b00) || (op[4:3] == s);
    endfunction

endpackage

// File: rtl/shape_processor_mc_channel.sv
// One channel: CTRL (shape + operation), saturating rejected-write counter
// and sticky error flag.
//   ctrl_we_i     : CTRL write strobe for this channel
//   status_clr_i  : STATUS write with the clear bit set
//   shape_field_i : raw shape field of the write data
//   op_field_i    : raw operation field of the write data
//   reject_o      : combinational, CTRL write this cycle is illegal
//   shape_o / operation_o / count_o / sticky_o : current register values
module shape_channel
    import shape_processor_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ctrl_we_i,
    input  logic             status_clr_i,
    input  logic [1:0]       shape_field_i,
    input  logic [4:0]       op_field_i,
    output logic             reject_o,
    output logic [1:0]       shape_o,
    output logic [4:0]       operation_o,
    output logic [CNT_W-1:0] count_o,
    output logic             sticky_o
);

    shape_t           shape_q;
    operation_t       op_q;
    logic [CNT_W-1:0] count_q;
    logic             sticky_q;

    shape_t     cand_shape;
    operation_t cand_op;
    logic       cand_legal;

    // All-ones fields mean "keep current"; legality is judged on the merge.
    assign cand_shape = (shape_field_i == SHAPE_KEEP) ? shape_q : shape_field_i;
    assign cand_op    = (op_field_i == OP_KEEP) ? op_q : op_field_i;
    assign cand_legal = is_legal_shape(cand_shape) && is_legal_operation(cand_op)
                        && is_legal_combination(cand_shape, cand_op);
    assign reject_o   = ctrl_we_i && !cand_legal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shape_q  <= SHAPE_RST;
            op_q     <= OP_RST;
            count_q  <= '0;
            sticky_q <= 1'b0;
        end else begin
            if (ctrl_we_i && cand_legal) begin
                shape_q <= cand_shape;
                op_q    <= cand_op;
            end
            if (status_clr_i) begin
                count_q  <= '0;
                sticky_q <= 1'b0;
            end else if (reject_o) begin
                if (count_q != '1) count_q <= count_q + CNT_W'(1);
                sticky_q <= 1'b1;
            end
        end
    end

    assign shape_o     = shape_q;
    assign operation_o = op_q;
    assign count_o     = count_q;
    assign sticky_o    = sticky_q;

endmodule

// File: rtl/shape_processor_mc.sv
// Multi-channel shape control register bank on the processor register bus.
// Address: bit 0 = register select (0 CTRL, 1 STATUS), upper bits = channel.
//   write / write_addr / write_data : write port, effective at the sampling edge
//   read / read_addr / read_data    : read port, read_data registered, held
//   error                           : one-cycle pulse for a rejected access
//   ctrl_shape / ctrl_operation     : per-channel current CTRL fields
module shape_processor_mc
    import shape_processor_pkg::*;
#(
    parameter int NUM_CHANNELS = 4,
    parameter int CNT_W        = 8,
    parameter int ADDR_W       = $clog2(NUM_CHANNELS) + 1
) (
    input  logic                      rst_n,
    input  logic                      clk,
    input  logic                      write,
    input  logic [ADDR_W-1:0]         write_addr,
    input  logic [31:0]               write_data,
    input  logic                      read,
    input  logic [ADDR_W-1:0]         read_addr,
    output logic [31:0]               read_data,
    output logic                      error,
    output logic [NUM_CHANNELS*2-1:0] ctrl_shape,
    output logic [NUM_CHANNELS*5-1:0] ctrl_operation
);

    logic [ADDR_W-1:0] wr_chan, rd_chan;
    logic              wr_oor, rd_oor;

    logic [NUM_CHANNELS-1:0]            reject;
    logic [NUM_CHANNELS-1:0][CNT_W-1:0] count;
    logic [NUM_CHANNELS-1:0]            sticky;

    logic [31:0] rd_word;
    logic [31:0] read_data_q;
    logic        error_d, error_q;

    assign wr_chan = write_addr >> 1;
    assign rd_chan = read_addr >> 1;
    assign wr_oor  = (wr_chan >= ADDR_W'(NUM_CHANNELS));
    assign rd_oor  = (rd_chan >= ADDR_W'(NUM_CHANNELS));

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_ch
        logic hit_w;
        assign hit_w = write && (wr_chan == ADDR_W'(g));

        shape_channel #(.CNT_W(CNT_W)) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .ctrl_we_i     (hit_w && (write_addr[0] == REG_CTRL)),
            .status_clr_i  (hit_w && (write_addr[0] == REG_STATUS) && write_data[CLEAR_BIT]),
            .shape_field_i (write_data[SHAPE_LSB+1:SHAPE_LSB]),
            .op_field_i    (write_data[OP_LSB+4:OP_LSB]),
            .reject_o      (reject[g]),
            .shape_o       (ctrl_shape[2*g +: 2]),
            .operation_o   (ctrl_operation[5*g +: 5]),
            .count_o       (count[g]),
            .sticky_o      (sticky[g])
        );
    end

    // Out-of-range channels match no iteration and read back as zero.
    always_comb begin
        rd_word = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (rd_chan == ADDR_W'(i)) begin
                if (read_addr[0] == REG_STATUS) begin
                    rd_word[CNT_W-1:0]  = count[i];
                    rd_word[STICKY_BIT] = sticky[i];
                end else begin
                    rd_word[SHAPE_LSB +: 2] = ctrl_shape[2*i +: 2];
                    rd_word[OP_LSB +: 5]    = ctrl_operation[5*i +: 5];
                end
            end
        end
    end

    // One pulse even when a bad read and a bad write land together.
    assign error_d = (write && wr_oor) || (|reject) || (read && rd_oor);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            read_data_q <= '0;
            error_q     <= 1'b0;
        end else begin
            error_q <= error_d;
            if (read) read_data_q <= rd_word;
        end
    end

    assign read_data = read_data_q;
    assign error     = error_q;

    logic unused_wdata;
    assign unused_wdata = ^{write_data[31:18], write_data[15:5]};

endmodule
